pal_and_plane: RTL and testbench

- Next-generation AND plane for the PAL fabric; replaces the fixed per-column AND reduction.
- Holds a serially loaded literal-mask configuration for N_TERMS product terms over N_INPUTS inputs and their complements.
- Evaluates every product term using only the literals selected by its mask; literals not selected are ignored rather than ANDed.
- Registered term outputs feed the downstream OR plane.

---
 rtl/pal_and_plane.sv | 98 +++++++++
 tb/tb_pal_and_plane.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pal_and_plane.sv
// Configurable PAL AND plane: a serially loaded literal mask per product term,
// with registered term results and per-term conflict flags.

module pal_term #(
  parameter int N_INPUTS = 4
) (
  input  logic [2*N_INPUTS-1:0] i_lit,
  input  logic [2*N_INPUTS-1:0] i_mask,
  output logic                  o_term,
  output logic                  o_conflict
);
  logic [N_INPUTS-1:0] w_both;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_pair
      assign w_both[gi] = i_mask[2*gi] & i_mask[2*gi+1];
    end
  endgenerate

  // Unselected literals are forced to 1; an empty mask must still give 0.
  assign o_term     = (|i_mask) & (&(i_lit | ~i_mask));
  assign o_conflict = |w_both;
endmodule

module pal_and_plane #(
  parameter  int N_INPUTS = 4,
  parameter  int N_TERMS  = 4,
  localparam int LW       = 2 * N_INPUTS,
  localparam int CFG_LEN  = N_TERMS * LW,
  localparam int CW       = $clog2(CFG_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic                cfg_bit,
  input  logic                cfg_restart,
  input  logic [N_INPUTS-1:0] data_in,
  output logic                cfg_valid,
  output logic [N_TERMS-1:0]  term_out,
  output logic [N_TERMS-1:0]  term_conflict
);
  logic [CFG_LEN-1:0] r_cfg;
  logic [CW-1:0]      r_cnt;
  logic               r_valid;
  logic [N_TERMS-1:0] r_term;
  logic [N_TERMS-1:0] r_conf;

  logic [LW-1:0]      w_lit;
  logic [N_TERMS-1:0] w_term;
  logic [N_TERMS-1:0] w_conf;

  genvar gi, gt;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_lit
      assign w_lit[2*gi]   = data_in[gi];
      assign w_lit[2*gi+1] = ~data_in[gi];
    end
    for (gt = 0; gt < N_TERMS; gt++) begin : g_term
      pal_term #(.N_INPUTS(N_INPUTS)) u_term (
        .i_lit      (w_lit),
        .i_mask     (r_cfg[gt*LW +: LW]),
        .o_term     (w_term[gt]),
        .o_conflict (w_conf[gt])
      );
    end
  endgenerate

  // Restart wins over a concurrent shift; a loaded config is frozen until restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (cfg_restart) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (cfg_en && !r_valid) begin
      r_cfg <= {cfg_bit, r_cfg[CFG_LEN-1:1]};
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(CFG_LEN - 1)) r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_term <= '0;
      r_conf <= '0;
    end else begin
      r_term <= r_valid ? w_term : '0;
      r_conf <= r_valid ? w_conf : '0;
    end
  end

  assign cfg_valid     = r_valid;
  assign term_out      = r_term;
  assign term_conflict = r_conf;
endmodule

// File: tb/tb_pal_and_plane.sv
// Bench for pal_and_plane: directed loads plus random traffic against a
// bit-history reference model of the configuration and literal semantics.

module tb_pal_and_plane;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en, cfg_bit, cfg_restart;
  logic [3:0] data_in;
  logic       cfg_valid;
  logic [3:0] term_out, term_conflict;

  int n_chk  = 0;
  int n_pass = 0;

  // model: every accepted config bit in arrival order, plus load progress
  bit   hist[$];
  int   m_cnt;
  bit   m_valid;
  logic [3:0] m_term, m_conf;

  pal_and_plane #(.N_INPUTS(4), .N_TERMS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_en        (cfg_en),
    .cfg_bit       (cfg_bit),
    .cfg_restart   (cfg_restart),
    .data_in       (data_in),
    .cfg_valid     (cfg_valid),
    .term_out      (term_out),
    .term_conflict (term_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // The register holds the 32 most recent bits; oldest of them lands at bit 0.
  function automatic logic [31:0] m_cfg();
    logic [31:0] c = '0;
    int n = hist.size();
    for (int j = 0; j < 32; j++) begin
      int idx = n - 32 + j;
      c[j] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return c;
  endfunction

  function automatic logic [3:0] f_terms(input logic [31:0] c, input logic [3:0] x);
    logic [3:0] r = '0;
    for (int t = 0; t < 4; t++) begin
      bit sel = 0, ok = 1;
      for (int i = 0; i < 4; i++) begin
        if (c[t*8+2*i])   begin sel = 1; if (!x[i]) ok = 0; end
        if (c[t*8+2*i+1]) begin sel = 1; if (x[i])  ok = 0; end
      end
      r[t] = sel && ok;
    end
    return r;
  endfunction

  function automatic logic [3:0] f_conf(input logic [31:0] c);
    logic [3:0] r = '0;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++)
        if (c[t*8+2*i] && c[t*8+2*i+1]) r[t] = 1'b1;
    return r;
  endfunction

  task automatic step(input logic en, input logic b, input logic rs, input logic [3:0] d);
    cfg_en = en; cfg_bit = b; cfg_restart = rs; data_in = d;
    @(posedge clk);
    m_term = m_valid ? f_terms(m_cfg(), d) : 4'h0;
    m_conf = m_valid ? f_conf(m_cfg()) : 4'h0;
    if (rs) begin
      m_cnt = 0; m_valid = 0;
    end else if (en && !m_valid) begin
      hist.push_back(b);
      m_cnt++;
      if (m_cnt == 32) m_valid = 1;
    end
    #1;
    chk("term_out", term_out, m_term);
    chk("term_conflict", term_conflict, m_conf);
    chk("cfg_valid", cfg_valid, m_valid);
  endtask

  task automatic load(input logic [31:0] c);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    for (int j = 0; j < 32; j++) step(1'b1, c[j], 1'b0, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 0; cfg_bit = 0; cfg_restart = 0; data_in = '0;
    m_cnt = 0; m_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_term", term_out, 4'h0);
    chk("rst_conf", term_conflict, 4'h0);
    @(negedge clk) rst_n = 1'b1;

    // term0 = x0 & x1
    load(32'h0000_0005);
    chk("valid_after_32", cfg_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'b0011); chk("t0_hit", term_out, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 4'b0010); chk("t0_miss", term_out, 4'b0000);

    // term1 = ~x0 & ~x1
    load(32'h0000_0A00);
    step(1'b0, 1'b0, 1'b0, 4'b0000); chk("t1_hit", term_out, 4'b0010);
    step(1'b0, 1'b0, 1'b0, 4'b0001); chk("t1_miss", term_out, 4'b0000);
    chk("t1_noconf", term_conflict, 4'h0);

    // term2 selects x0 and ~x0
    load(32'h0003_0000);
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 1'b0, 1'b0, 4'(v));
      chk("t2_conf", term_conflict, 4'b0100);
      chk("t2_zero", {31'd0, term_out[2]}, 32'd0);
    end

    // empty masks never fire
    load(32'h0000_0000);
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 1'b0, 1'b0, 4'(v));
      chk("empty_zero", term_out, 4'h0);
    end
    chk("empty_valid", cfg_valid, 1'b1);

    // restart colliding with a shift mid-load
    step(1'b0, 1'b0, 1'b1, 4'h0);
    for (int j = 0; j < 20; j++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'h3);
    step(1'b1, 1'b1, 1'b1, 4'h3);
    chk("restart_valid", cfg_valid, 1'b0);
    chk("restart_term", term_out, 4'h0);
    for (int j = 0; j < 32; j++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
    chk("reload_valid", cfg_valid, 1'b1);
    for (int v = 0; v < 16; v++) step(1'b0, 1'b0, 1'b0, 4'(v));

    // shifts while loaded must be ignored
    for (int j = 0; j < 10; j++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'h5);
    for (int v = 0; v < 16; v++) step(1'b0, 1'b0, 1'b0, 4'(v));

    // async reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", cfg_valid, 1'b0);
    chk("arst_term", term_out, 4'h0);
    chk("arst_conf", term_conflict, 4'h0);
    hist.delete(); m_cnt = 0; m_valid = 0;
    @(negedge clk) rst_n = 1'b1;

    // random traffic with occasional restarts and full loads
    for (int k = 0; k < 600; k++) begin
      logic rs = ($urandom_range(0, 99) < 2);
      logic en = ($urandom_range(0, 99) < 80);
      step(en, 1'($urandom_range(0, 1)), rs, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
